// File: rtl/sequence_detector.sv
// Byte-stream detector for the fixed 8-byte pattern AF BC E2 78 FF E2 0B 8D.
// Define SEQ_DETECT_COUNT_EN to build in the saturating 16-bit detection counter.
module sequence_detector #(
    parameter int SEQ_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic        detected,
    output logic        sync_err,
    output logic [2:0]  progress,
    output logic [15:0] det_count
);

    localparam logic [2:0] LAST_IDX  = 3'(SEQ_LEN - 1);
    localparam logic [7:0] HEAD_BYTE = 8'hAF;

    function automatic logic [7:0] pattern_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    pattern_byte = 8'hAF;
            3'd1:    pattern_byte = 8'hBC;
            3'd2:    pattern_byte = 8'hE2;
            3'd3:    pattern_byte = 8'h78;
            3'd4:    pattern_byte = 8'hFF;
            3'd5:    pattern_byte = 8'hE2;
            3'd6:    pattern_byte = 8'h0B;
            default: pattern_byte = 8'h8D;
        endcase
    endfunction

    logic [2:0] progress_q, progress_d;
    logic       detected_q, detected_d;
    logic       sync_err_q, sync_err_d;

    always_comb begin
        progress_d = progress_q;
        detected_d = 1'b0;
        sync_err_d = 1'b0;
        if (valid) begin
            if (data == pattern_byte(progress_q)) begin
                if (progress_q == LAST_IDX) begin
                    progress_d = 3'd0;
                    detected_d = 1'b1;
                end else begin
                    progress_d = progress_q + 3'd1;
                end
            end else begin
                // AF is the only prefix that can restart a match on the breaking byte.
                progress_d = (data == HEAD_BYTE) ? 3'd1 : 3'd0;
                sync_err_d = (progress_q != 3'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            progress_q <= 3'd0;
            detected_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            progress_q <= progress_d;
            detected_q <= detected_d;
            sync_err_q <= sync_err_d;
        end
    end

`ifdef SEQ_DETECT_COUNT_EN
    logic [15:0] det_count_q, det_count_d;

    always_comb begin
        det_count_d = det_count_q;
        if (detected_d && det_count_q != 16'hFFFF)
            det_count_d = det_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) det_count_q <= 16'd0;
        else     det_count_q <= det_count_d;
    end

    assign det_count = det_count_q;
`else
    assign det_count = 16'd0;
`endif

    assign progress = progress_q;
    assign detected = detected_q;
    assign sync_err = sync_err_q;

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 SHALL define parameter SEQ_LEN, default 8, the number of bytes in the fixed pattern; only the value 8 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port valid  input  1  data qualifies a byte this cycle.
REQ-005 SHALL have port data  input  8  received byte.
REQ-006 SHALL have port detected  output  1  one-cycle pulse when the full pattern has been matched.
REQ-007 SHALL have port sync_err  output  1  one-cycle pulse when a partial match is broken.
REQ-008 SHALL have port progress  output  3  count of pattern bytes currently matched (0..7).
REQ-009 SHALL have port det_count  output  16  count of completed detections.

Function
REQ-010 SHALL use the fixed pattern AF, BC, E2, 78, FF, E2, 0B, 8D, in that order; index 0 is AF.
REQ-011 SHALL accept a byte only on a cycle with valid=1; with valid=0, every register holds and detected and sync_err are 0.
REQ-012 SHALL use the state register progress (0..7) to select the expected byte pattern[progress].
REQ-013 SHALL treat an accepted byte that equals the expected byte with progress<7 as a match: progress increments.
REQ-014 SHALL treat an accepted byte that equals 8D with progress=7 as a completion: progress becomes 0, detected pulses the next cycle, and det_count increments.
REQ-015 SHALL treat an accepted mismatching byte as a re-sync: progress becomes 1 if the byte is AF, else 0.
REQ-016 SHALL pulse sync_err for one cycle on a mismatch only when progress was greater than 0 before the byte; a mismatch at progress 0 produces no error.
REQ-017 SHALL have non-overlapping detection; since AF is the only self-overlap prefix, REQ-015 is the complete failure rule.
REQ-018 SHALL register detected and sync_err, with latency exactly one cycle after the accepting clock edge; the two are never asserted together.
REQ-019 SHALL support back-to-back patterns: AF as the first byte after a completion advances progress to 1 with no gap cycle required.
REQ-020 SHALL saturate det_count at FFFF; it never wraps.
REQ-021 SHALL drive progress directly from the state register (no extra latency).

Reset
REQ-022 SHALL, when rst=1 at a rising clk edge, set progress=0, detected=0, sync_err=0, det_count=0.
REQ-023 SHALL give rst priority over valid; a byte presented during reset is discarded, and a partial match in progress is abandoned without a sync_err pulse.
REQ-024 SHALL, on the first cycle after rst deasserts, be able to accept a byte.

Configuration
REQ-025 SHALL provide the macro SEQ_DETECT_COUNT_EN to compile the detection counter in or out.
REQ-026 SHALL, when SEQ_DETECT_COUNT_EN is defined, implement det_count per REQ-014 and REQ-020.
REQ-027 SHALL, when SEQ_DETECT_COUNT_EN is undefined, tie det_count constant 0, instantiate no counter flops, and leave all other behaviour unchanged.

Verification
REQ-028 SHALL cover clean detection: valid=1 with AF BC E2 78 FF E2 0B 8D on consecutive cycles -> progress steps 1..7 then 0, detected=1 for exactly one cycle after 8D, det_count=1.
REQ-029 SHALL cover back-to-back patterns: the full pattern twice with no gap -> two detected pulses 8 cycles apart, det_count=2, sync_err never 1.
REQ-030 SHALL cover mismatch with re-sync: AF BC E2 AF BC E2 78 FF E2 0B 8D -> sync_err pulses after the 4th byte, progress=1 after it, then one detected pulse.
REQ-031 SHALL cover valid gaps: the pattern with valid=0 for 3 cycles inserted after 78 -> progress holds at 4 during the gap, then one detected pulse.
REQ-032 SHALL cover reset mid-pattern: AF BC E2 78, then rst=1 for one cycle, then BC -> progress=0, sync_err=0, det_count=0, and BC does not advance progress.
REQ-033 SHALL cover saturation (SEQ_DETECT_COUNT_EN defined): preload det_count near FFFF and apply 2 patterns -> det_count stays FFFF; with the macro undefined, det_count=0 throughout.
